u_mcb_read_check: RTL

- Downstream verification stage of the DDR3 memory test.
- Reads back each 64-beat burst once the write side reports a completed write command. Read commands go to the same MCB user read port.
- Compares every 128-bit beat against the known alternating write pattern and exposes sticky error, error count, burst pass count and first-failure capture for LEDs/ChipScope.

---
 rtl/mcb_test_pkg.sv | 37 +++
 rtl/u_mcb_read_check_pat_check.sv | 62 ++++++
 rtl/u_mcb_read_check.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mcb_test_pkg.sv
// Shared constants for the DDR3 MCB memory test: burst geometry, address walk,
// data pattern and read-check FSM encoding.
package mcb_test_pkg;

  localparam int unsigned BURST_LEN = 64;
  localparam int unsigned TIMEOUT   = 4096;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned BEAT_W = 6;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned WDOG_W = $clog2(TIMEOUT);
  localparam int unsigned PEND_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_INC = 30'h400;
  localparam logic [ADDR_W-1:0] END_ADDR = 30'h1000_0000 - 30'h400;
  localparam logic [DATA_W-1:0] PAT_EVEN = {4{32'hAAAA_AAAA}};

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  // Burst address walk shared with the write generator; wraps after END_ADDR.
  function automatic logic [ADDR_W-1:0] next_burst_addr(input logic [ADDR_W-1:0] addr);
    return (addr == END_ADDR) ? '0 : addr + ADDR_INC;
  endfunction

  function automatic logic [DATA_W-1:0] expected_beat(input logic [BEAT_W-1:0] beat);
    return beat[0] ? ~PAT_EVEN : PAT_EVEN;
  endfunction

endpackage

// File: rtl/u_mcb_read_check_pat_check.sv
// Beat comparator: expected-pattern generation, saturating mismatch count and
// first-failure capture (address and beat index of the first bad beat).
module u_pat_check
  import mcb_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              chk_en,
  input  logic [BEAT_W-1:0] beat,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              mismatch,
  output logic              err_flag,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [BEAT_W-1:0] fail_beat
);

  logic              err_flag_q, err_flag_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [BEAT_W-1:0] fail_beat_q, fail_beat_d;

  assign mismatch = chk_en && (data != expected_beat(beat));

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_beat_d = fail_beat_q;
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!err_flag_q) begin
        err_flag_d  = 1'b1;
        fail_addr_d = addr;
        fail_beat_d = beat;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_beat_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_beat_q <= fail_beat_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_beat = fail_beat_q;

endmodule

// File: rtl/u_mcb_read_check.sv
// Read-back stage of the DDR3 memory test: issues one read burst per completed
// write burst, checks every beat and keeps sticky status and counters.
module u_mcb_read_check
  import mcb_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              u_wr_cmd_done,
  input  logic              u_rd_cmd_done,
  input  logic              u_rd_data_valid,
  input  logic [DATA_W-1:0] u_rd_data,
  output logic              u_rd_cmd_en,
  output logic [ADDR_W-1:0] u_rd_addr,
  output logic [LEN_W-1:0]  u_rd_len,
  output logic              err_flag,
  output logic [15:0]       err_cnt,
  output logic [31:0]       pass_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [BEAT_W-1:0] fail_beat,
  output logic              timeout_flag,
  output logic              ovf_flag
);

  rd_state_e         state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0] rd_addr_set_q, rd_addr_set_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cmd_en_q, cmd_en_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              burst_err_q, burst_err_d;
  logic [31:0]       pass_cnt_q, pass_cnt_d;
  logic              timeout_q, timeout_d;
  logic              ovf_q, ovf_d;

  logic cmd_accept;
  logic chk_en;
  logic last_beat;
  logic mismatch;

  assign cmd_accept = cmd_en_q && u_rd_cmd_done;
  assign chk_en     = (state_q == RD_DATA) && u_rd_data_valid;
  assign last_beat  = chk_en && (beat_q == LAST_BEAT);

  u_pat_check u_pat_check_i (
    .clk       (clk),
    .rst       (rst),
    .chk_en    (chk_en),
    .beat      (beat_q),
    .addr      (rd_addr_q),
    .data      (u_rd_data),
    .mismatch  (mismatch),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_beat (fail_beat)
  );

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    rd_addr_set_d = rd_addr_set_q;
    rd_addr_d     = rd_addr_q;
    cmd_en_d      = cmd_en_q;
    beat_d        = beat_q;
    wdog_d        = wdog_q;
    burst_err_d   = burst_err_q;
    pass_cnt_d    = pass_cnt_q;
    timeout_d     = timeout_q;
    ovf_d         = ovf_q;

    // A write completion and a read accept in the same cycle cancel out.
    case ({u_wr_cmd_done, cmd_accept})
      2'b10: begin
        if (pending_q == '1) ovf_d = 1'b1;
        else                 pending_d = pending_q + 4'd1;
      end
      2'b01:   pending_d = pending_q - 4'd1;
      default: ;
    endcase

    case (state_q)
      RD_IDLE: begin
        if (pending_q != '0) begin
          rd_addr_d = rd_addr_set_q;
          cmd_en_d  = 1'b1;
          state_d   = RD_CMD;
        end
      end
      RD_CMD: begin
        if (u_rd_cmd_done) begin
          cmd_en_d      = 1'b0;
          rd_addr_set_d = next_burst_addr(rd_addr_set_q);
          beat_d        = '0;
          wdog_d        = '0;
          burst_err_d   = 1'b0;
          state_d       = RD_DATA;
        end
      end
      RD_DATA: begin
        if (chk_en) begin
          beat_d = beat_q + 6'd1;
          if (mismatch) burst_err_d = 1'b1;
        end
        // The final beat wins over a watchdog expiry landing in the same cycle.
        if (last_beat) begin
          state_d = RD_IDLE;
          if (!burst_err_q && !mismatch) pass_cnt_d = pass_cnt_q + 32'd1;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_d = 1'b1;
          state_d   = RD_IDLE;
        end else begin
          wdog_d = wdog_q + 12'd1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RD_IDLE;
      pending_q     <= '0;
      rd_addr_set_q <= '0;
      rd_addr_q     <= '0;
      cmd_en_q      <= 1'b0;
      beat_q        <= '0;
      wdog_q        <= '0;
      burst_err_q   <= 1'b0;
      pass_cnt_q    <= '0;
      timeout_q     <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rd_addr_set_q <= rd_addr_set_d;
      rd_addr_q     <= rd_addr_d;
      cmd_en_q      <= cmd_en_d;
      beat_q        <= beat_d;
      wdog_q        <= wdog_d;
      burst_err_q   <= burst_err_d;
      pass_cnt_q    <= pass_cnt_d;
      timeout_q     <= timeout_d;
      ovf_q         <= ovf_d;
    end
  end

  assign u_rd_cmd_en  = cmd_en_q;
  assign u_rd_addr    = rd_addr_q;
  assign u_rd_len     = LEN_W'(BURST_LEN);
  assign pass_cnt     = pass_cnt_q;
  assign timeout_flag = timeout_q;
  assign ovf_flag     = ovf_q;

endmodule
